// File: rtl/spike_pkg.sv
// spike_pkg: shared FSM state types and packet layout for the spike interconnect receive side.
// Contents: in_state_t, out_state_t, DEF_WIDTH, DEST_BIT, packet_t.
package spike_pkg;
   typedef enum logic {IN_IDLE, IN_HOLD} in_state_t;
   typedef enum logic [1:0] {O_IDLE, O_REQ, O_REL} out_state_t;
   localparam int DEF_WIDTH = 2;
   // The destination tag is the bit just above the payload.
   localparam int DEST_BIT = DEF_WIDTH;
   typedef struct packed {
      logic dest;
      logic [DEF_WIDTH-1:0] payload;
   } packet_t;
endpackage

// File: rtl/split_router.sv
// split_router: steers tagged 4-phase packets, tag stripped, to one of two 4-phase outputs.
// Ports: clk, rst (sync, active-high); in_req/in_data/in_ack upstream channel;
// out0_req/out0_data/out0_ack and out1_req/out1_data/out1_ack downstream channels;
// cnt0/cnt1 count completed handshakes per output (wrapping).
module split_router
   import spike_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_req,
   input  logic [WIDTH:0]   in_data,
   output logic             in_ack,
   output logic             out0_req,
   output logic [WIDTH-1:0] out0_data,
   input  logic             out0_ack,
   output logic             out1_req,
   output logic [WIDTH-1:0] out1_data,
   input  logic             out1_ack,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);
   in_state_t  in_st;
   out_state_t out_st;
   logic [WIDTH:0] buf_q;
   logic buf_full;
   logic dest;
   logic launch;
   logic capture;
   logic ack_sel;
   always_comb begin
      launch  = (out_st == O_IDLE) && buf_full;
      // A launch this cycle frees the buffer, so capture may bypass the full flag.
      capture = (in_st == IN_IDLE) && in_req && (!buf_full || launch);
      // Only the selected destination's ack is observed.
      ack_sel = dest ? out1_ack : out0_ack;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         in_st     <= IN_IDLE;
         out_st    <= O_IDLE;
         buf_q     <= '0;
         buf_full  <= 1'b0;
         dest      <= 1'b0;
         in_ack    <= 1'b0;
         out0_req  <= 1'b0;
         out1_req  <= 1'b0;
         out0_data <= '0;
         out1_data <= '0;
         cnt0      <= '0;
         cnt1      <= '0;
      end else begin
         if (capture) buf_q <= in_data;
         buf_full <= capture | (buf_full & ~launch);
         if (in_st == IN_IDLE) begin
            if (capture) begin
               in_ack <= 1'b1;
               in_st  <= IN_HOLD;
            end
         end else if (!in_req) begin
            in_ack <= 1'b0;
            in_st  <= IN_IDLE;
         end
         unique case (out_st)
            O_IDLE: if (buf_full) begin
               dest <= buf_q[WIDTH];
               if (buf_q[WIDTH]) begin
                  out1_data <= buf_q[WIDTH-1:0];
                  out1_req  <= 1'b1;
               end else begin
                  out0_data <= buf_q[WIDTH-1:0];
                  out0_req  <= 1'b1;
               end
               out_st <= O_REQ;
            end
            O_REQ: if (ack_sel) begin
               out0_req <= 1'b0;
               out1_req <= 1'b0;
               if (dest) cnt1 <= cnt1 + CNT_W'(1);
               else cnt0 <= cnt0 + CNT_W'(1);
               out_st <= O_REL;
            end
            O_REL: if (!ack_sel) out_st <= O_IDLE;
            default: out_st <= O_IDLE;
         endcase
      end
   end
endmodule
